// File: rtl/clk_ratio_monitor_pkg.sv
// Shared definitions for the divided-clock ratio monitor.
// Holds the default counter width, synchroniser depth and lock depth.
// Also holds the saturating helper for the lock match counter.
package clk_ratio_monitor_pkg;

    localparam int CNT_W_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int LOCK_COUNT_DEF  = 4;
    localparam int LOCK_COUNT_MAX  = 15;
    localparam int MATCH_W         = 4;

    // Increment that stops at 'limit' rather than wrapping.
    function automatic logic [MATCH_W-1:0] sat_inc(input logic [MATCH_W-1:0] val,
                                                   input logic [MATCH_W-1:0] limit);
        if (val >= limit) begin
            return limit;
        end else begin
            return val + 4'd1;
        end
    endfunction

endpackage

// File: rtl/clk_ratio_monitor_sync_ff.sv
// sync_ff: STAGES-deep flop chain bringing 'd' into the clk domain.
// With STAGES = 0 the chain is a plain wire (input already synchronous).
// Ports:
//   clk   in  sampling clock
//   rst_n in  asynchronous active-low clear; the chain clears to 0
//   d     in  asynchronous input
//   q     out synchronised output
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (STAGES == 0) begin : g_wire
        assign q = d;
    end else begin : g_chain
        logic [STAGES-1:0] chain_q;

        // Shift the input through the synchroniser chain.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain_q <= {STAGES{1'b0}};
            end else begin
                chain_q[0] <= d;
                for (int i = 1; i < STAGES; i++) begin
                    chain_q[i] <= chain_q[i-1];
                end
            end
        end

        assign q = chain_q[STAGES-1];
    end

endmodule

// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor: samples a slow divided clock in the fast clk domain,
// measures its period and high time in clk cycles, declares lock after
// LOCK_COUNT identical measurements, flags ratio changes while locked and
// reports a lost clock.
// Ports:
//   clk        in  sampling clock, all logic on posedge
//   reset      in  asynchronous active-low reset
//   div_in     in  divided clock under test
//   period     out last measured period (rise to rise)
//   high_time  out last measured high time (rise to fall)
//   meas_valid out 1-cycle pulse, period/high_time updated
//   locked     out level, LOCK_COUNT identical measurements seen
//   mismatch   out 1-cycle pulse, measurement changed while locked
//   timeout    out level, no rising edge for 2**CNT_W-1 cycles
module clk_ratio_monitor
    import clk_ratio_monitor_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int LOCK_COUNT  = LOCK_COUNT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             timeout
);

    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
    // One below all-ones: the count that would saturate on the next cycle.
    localparam logic [CNT_W-1:0]   CNT_SAT = CNT_MAX - CNT_ONE;
    localparam logic [MATCH_W-1:0] LOCK_N  = MATCH_W'(LOCK_COUNT);

    logic s_sync;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (div_in),
        .q     (s_sync)
    );

    logic               s_prev_q,      s_prev_d;
    logic               rise_q,        rise_d;
    logic               fall_q,        fall_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [CNT_W-1:0]   high_q,        high_d;
    logic               seen_rise_q,   seen_rise_d;
    logic [MATCH_W-1:0] match_q,       match_d;
    logic [CNT_W-1:0]   period_q,      period_d;
    logic [CNT_W-1:0]   high_time_q,   high_time_d;
    logic               meas_valid_q,  meas_valid_d;
    logic               locked_q,      locked_d;
    logic               mismatch_q,    mismatch_d;
    logic               timeout_q,     timeout_d;

    logic [CNT_W-1:0]   meas_period_s;
    logic               near_sat_s;
    logic               same_s;

    // Edge detect, cycle counter, capture and lock bookkeeping.
    always_comb begin
        s_prev_d     = s_sync;
        rise_d       = s_sync & ~s_prev_q;
        fall_d       = ~s_sync & s_prev_q;
        cnt_d        = cnt_q;
        seen_rise_d  = seen_rise_q;
        match_d      = match_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        mismatch_d   = 1'b0;
        timeout_d    = timeout_q;

        meas_period_s = cnt_q + CNT_ONE;
        near_sat_s    = (cnt_q >= CNT_SAT);
        same_s        = (meas_period_s == period_q) && (high_q == high_time_q);

        if (fall_q) begin
            high_d = cnt_q + CNT_ONE;
        end else begin
            high_d = high_q;
        end

        if (rise_q) begin
            cnt_d = {CNT_W{1'b0}};
            if (timeout_q) begin
                // Clock came back: re-arm only, the interval is meaningless.
                timeout_d   = 1'b0;
                seen_rise_d = 1'b1;
            end else if (!seen_rise_q || near_sat_s) begin
                // First rise, or a rise coinciding with saturation: arm only.
                seen_rise_d = 1'b1;
            end else begin
                period_d     = meas_period_s;
                high_time_d  = high_q;
                meas_valid_d = 1'b1;
                if (match_q == {MATCH_W{1'b0}}) begin
                    match_d = {{(MATCH_W-1){1'b0}}, 1'b1};
                end else if (same_s) begin
                    match_d = sat_inc(match_q, LOCK_N);
                end else begin
                    match_d    = {{(MATCH_W-1){1'b0}}, 1'b1};
                    mismatch_d = locked_q;
                end
                locked_d = (match_d == LOCK_N);
            end
        end else if (near_sat_s) begin
            cnt_d       = CNT_MAX;
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            match_d     = {MATCH_W{1'b0}};
            seen_rise_d = 1'b0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_prev_q     <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
            high_q       <= {CNT_W{1'b0}};
            seen_rise_q  <= 1'b0;
            match_q      <= {MATCH_W{1'b0}};
            period_q     <= {CNT_W{1'b0}};
            high_time_q  <= {CNT_W{1'b0}};
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            mismatch_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            s_prev_q     <= s_prev_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            cnt_q        <= cnt_d;
            high_q       <= high_d;
            seen_rise_q  <= seen_rise_d;
            match_q      <= match_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            mismatch_q   <= mismatch_d;
            timeout_q    <= timeout_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign mismatch   = mismatch_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Directed bench for clk_ratio_monitor: one instance without synchroniser
// (SYNC_STAGES=0) and one with SYNC_STAGES=2, both fed the same div_in.
module tb_clk_ratio_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       div_in = 1'b0;

    logic [7:0] period0, high0, period2, high2;
    logic       mv0, lk0, mm0, to0;
    logic       mv2, lk2, mm2, to2;

    int errors = 0;
    int checks = 0;

    // pulse counters sampled on the falling edge
    int   mv0_cnt = 0;
    int   mm0_cnt = 0;
    int   lock_at0 = 0;
    logic lk0_prev = 1'b0;
    int   base_mv;
    int   base_mm;

    always #5 clk = ~clk;

    clk_ratio_monitor #(.CNT_W(8), .SYNC_STAGES(0), .LOCK_COUNT(4)) dut0 (
        .clk(clk), .reset(reset), .div_in(div_in),
        .period(period0), .high_time(high0), .meas_valid(mv0),
        .locked(lk0), .mismatch(mm0), .timeout(to0)
    );

    clk_ratio_monitor #(.CNT_W(8), .SYNC_STAGES(2), .LOCK_COUNT(4)) dut2 (
        .clk(clk), .reset(reset), .div_in(div_in),
        .period(period2), .high_time(high2), .meas_valid(mv2),
        .locked(lk2), .mismatch(mm2), .timeout(to2)
    );

    always @(negedge clk) begin
        mv0_cnt  <= mv0_cnt + (mv0 ? 1 : 0);
        mm0_cnt  <= mm0_cnt + (mm0 ? 1 : 0);
        if (lk0 && !lk0_prev) begin
            lock_at0 <= mv0_cnt + (mv0 ? 1 : 0);
        end
        lk0_prev <= lk0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            div_in = 1'b1;
            repeat (hi) cyc();
            div_in = 1'b0;
            repeat (lo) cyc();
        end
    endtask

    task automatic pulse_reset();
        div_in = 1'b0;
        reset  = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        // reset state
        #2;
        check("rst_period",   32'(period0), 32'd0);
        check("rst_high",     32'(high0),   32'd0);
        check("rst_mv",       32'(mv0),     32'd0);
        check("rst_locked",   32'(lk0),     32'd0);
        check("rst_mismatch", 32'(mm0),     32'd0);
        check("rst_timeout",  32'(to0),     32'd0);
        check("rst_period2",  32'(period2), 32'd0);
        repeat (2) cyc();
        reset = 1'b1;
        cyc();

        // 1: clk/2
        base_mv = mv0_cnt; base_mm = mm0_cnt;
        run(1, 1, 6);
        cyc();
        check("div2_period",  32'(period0), 32'd2);
        check("div2_high",    32'(high0),   32'd1);
        check("div2_locked",  32'(lk0),     32'd1);
        check("div2_nmeas",   32'(mv0_cnt - base_mv), 32'd5);
        check("div2_lock_at", 32'(lock_at0 - base_mv), 32'd4);
        check("div2_nmm",     32'(mm0_cnt - base_mm), 32'd0);

        // 2: div-by-4, then div-by-6
        pulse_reset();
        base_mv = mv0_cnt;
        run(2, 2, 6);
        check("div4_period", 32'(period0), 32'd4);
        check("div4_high",   32'(high0),   32'd2);
        check("div4_locked", 32'(lk0),     32'd1);
        check("div4_nmeas",  32'(mv0_cnt - base_mv), 32'd5);
        pulse_reset();
        base_mv = mv0_cnt;
        run(3, 3, 6);
        check("div6_period",  32'(period0), 32'd6);
        check("div6_high",    32'(high0),   32'd3);
        check("div6_locked",  32'(lk0),     32'd1);
        check("div6_lock_at", 32'(lock_at0 - base_mv), 32'd4);

        // 3: 1-in-5 pulse, then switch to div-by-6
        pulse_reset();
        base_mv = mv0_cnt; base_mm = mm0_cnt;
        run(1, 4, 6);
        check("p5_period", 32'(period0), 32'd5);
        check("p5_high",   32'(high0),   32'd1);
        check("p5_locked", 32'(lk0),     32'd1);
        base_mv = mv0_cnt;
        run(3, 3, 2);
        check("sw_mismatches", 32'(mm0_cnt - base_mm), 32'd1);
        check("sw_unlocked",   32'(lk0),     32'd0);
        check("sw_period",     32'(period0), 32'd6);
        check("sw_high",       32'(high0),   32'd3);
        run(3, 3, 3);
        check("relock",         32'(lk0), 32'd1);
        check("relock_at",      32'(lock_at0 - base_mv), 32'd5);
        check("relock_nmeas",   32'(mv0_cnt - base_mv), 32'd5);

        // 4: lost clock, then resume div-by-4
        base_mm = mm0_cnt;
        repeat (240) cyc();
        check("to_not_yet", 32'(to0), 32'd0);
        check("to_still_locked", 32'(lk0), 32'd1);
        repeat (20) cyc();
        check("to_set",      32'(to0),     32'd1);
        check("to_unlocked", 32'(lk0),     32'd0);
        check("to_hold_per", 32'(period0), 32'd6);
        check("to_no_mm",    32'(mm0_cnt - base_mm), 32'd0);
        base_mv = mv0_cnt;
        run(2, 2, 1);
        check("resume_to_clr", 32'(to0), 32'd0);
        check("resume_nomeas", 32'(mv0_cnt - base_mv), 32'd0);
        run(2, 2, 1);
        check("resume_meas",   32'(mv0_cnt - base_mv), 32'd1);
        check("resume_period", 32'(period0), 32'd4);
        check("resume_high",   32'(high0),   32'd2);
        check("resume_unlock", 32'(lk0),     32'd0);

        // 5: reset mid-period while locked
        run(2, 2, 4);
        check("pre_rst_locked", 32'(lk0), 32'd1);
        div_in = 1'b1;
        cyc();
        reset = 1'b0;
        #2;
        check("async_period", 32'(period0), 32'd0);
        check("async_high",   32'(high0),   32'd0);
        check("async_locked", 32'(lk0),     32'd0);
        check("async_timeout",32'(to0),     32'd0);
        div_in = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        base_mv = mv0_cnt;
        run(2, 2, 1);
        check("post_rst_nomeas", 32'(mv0_cnt - base_mv), 32'd0);
        run(2, 2, 1);
        check("post_rst_meas",   32'(mv0_cnt - base_mv), 32'd1);

        // 6: two-stage synchroniser, div-by-8 latency
        pulse_reset();
        run(4, 4, 3);
        div_in = 1'b1;
        cyc();
        check("lat0_c1", 32'(mv0), 32'd0);
        cyc();
        check("lat0_c2", 32'(mv0), 32'd1);
        cyc();
        check("lat2_c3", 32'(mv2), 32'd0);
        cyc();
        check("lat2_c4", 32'(mv2), 32'd1);
        div_in = 1'b0;
        repeat (4) cyc();
        check("div8_period2", 32'(period2), 32'd8);
        check("div8_high2",   32'(high2),   32'd4);

        // stuck high ends in timeout without a mismatch pulse
        base_mm = mm0_cnt;
        div_in = 1'b1;
        repeat (270) cyc();
        check("stuck_hi_to",  32'(to0), 32'd1);
        check("stuck_hi_to2", 32'(to2), 32'd1);
        check("stuck_hi_nmm", 32'(mm0_cnt - base_mm), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
